branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Next-generation branch unit for the pipelined MIPS core.
- Resolves six branch conditions in EX from ALU flags, in place of the beq/bne-only decision.
- Holds a direct-mapped table of 2-bit saturating counters that supplies a taken/not-taken prediction to IF.
- Flags mispredictions so the hazard unit can flush.

Parameters:
- IDX_W, 4, table index width; table depth = 2**IDX_W entries.
- PC_W, 32, program counter width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_pc  input  PC_W  PC of instruction in IF.
- if_pred_taken  output  1  prediction for if_pc; combinational table read.
- ex_valid  input  1  EX holds a valid instruction.
- ex_stall  input  1  EX frozen this cycle; suppresses table update.
- ex_pc  input  PC_W  PC of instruction in EX.
- ex_br_op  input  3  0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 illegal.
- ex_zero  input  1  ALU result == 0.
- ex_neg  input  1  ALU result sign bit.
- ex_pred_taken  input  1  prediction made for this instruction in IF, carried down the pipeline.
- branch_taken  output  1  resolved outcome (branch control to PC mux).
- mispredict  output  1  resolved outcome differs from ex_pred_taken; request flush.
- br_err  output  1  illegal ex_br_op seen while ex_valid.

Behaviour:
- Index: idx = pc[IDX_W+1:2], for both if_pc and ex_pc. There are no tags, so aliasing is allowed.
- Prediction: if_pred_taken = counter[idx(if_pc)][1]. Zero latency.
- Resolution is combinational, with zero latency.
  - BEQ taken = zero. BNE taken = !zero.
  - BLEZ taken = zero | neg. BGTZ taken = !zero & !neg.
  - BLTZ taken = neg. BGEZ taken = !neg.
  - NONE: taken = 0.
  - Illegal (op 7): taken = 0 and br_err = 1.
- Qualification: all of branch_taken, mispredict and br_err are 0 when ex_valid = 0.
- mispredict = ex_valid & (op in 1..6) & (branch_taken != ex_pred_taken).
  - NONE and illegal ops never assert mispredict.
- Counter per entry, 2 bits: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update condition: on the rising edge when ex_valid & !ex_stall & op in 1..6.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Update timing: the entry at idx(ex_pc) is written at the edge. There is no read bypass.
  - When IF and EX hit the same index in the same cycle, IF sees the pre-update value.
  - The new value is visible from the next cycle.
- Only one entry is written per cycle.
- Reset (asynchronous, rst_n = 0): every counter goes to 01 (weak-NT) immediately.
  - Prediction outputs therefore read 0 during and after reset.
  - Combinational outputs follow their inputs; the bench holds ex_valid = 0 during reset.
- Reset asserted mid-update: the update is lost and the table holds its reset value.
- No other hidden state; the block has no FSM beyond the counter array.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - br_count [31:0]: increments on each qualified update.
  - mp_count [31:0]: increments on each qualified update with mispredict = 1.
- Counter behaviour: both reset to 0 asynchronously, wrap modulo 2**32, and are frozen by ex_stall.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (core-wide defines file):
  - branch op encodings BR_NONE..BR_BGEZ, BR_ILLEGAL;
  - counter state constants SC_SNT, SC_WNT, SC_WT, SC_ST;
  - default IDX_W.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down step function. It is instantiated inline per update path.
- Resolution logic stays in the top module.

Test Plan:
- Reset → counter array and prediction:
  - Assert rst_n = 0 mid-run, release, sweep if_pc over 0x00..0x3C.
  - Required: if_pred_taken = 0 at every index; the bench peeks every counter = 01.
- Condition truth table → branch_taken:
  - With ex_valid = 1, sweep all ops × {zero, neg} ∈ {00, 01, 10}.
  - Required: taken matches the rules, e.g. BLEZ with zero = 0, neg = 1 gives 1; BGTZ with 00 gives 1.
  - Required: op 7 gives br_err = 1 and taken = 0.
- Training and saturation → counter and mispredict:
  - Five taken BEQ at ex_pc = 0x40, ex_pred_taken taken from if_pred_taken.
  - Required: counter 01→10→11→11→11; mispredict only on the first.
  - Then one not-taken: counter 10, prediction stays 1.
- Same-index collision → no bypass:
  - In one cycle, if_pc = ex_pc = 0x80, counter at 01, taken update.
  - Required: if_pred_taken = 0 that cycle and 1 the next.
- Stall and invalid → no update:
  - ex_stall = 1 with a taken BNE, then ex_valid = 0 with op BEQ.
  - Required: counter unchanged; mispredict and br_err both 0 in the invalid case.
- With BRANCH_PERF_CNT_EN defined → counters:
  - 10 branches, 3 mispredicted, plus 2 stalled.
  - Required: br_count = 10, mp_count = 3.
  - Preload to 0xFFFFFFFF, then one branch: br_count wraps to 0.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared branch op encodings, counter states and table defaults
package branch_predict_unit_pkg;

  localparam int IDX_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    BR_NONE    = 3'd0,
    BR_BEQ     = 3'd1,
    BR_BNE     = 3'd2,
    BR_BLEZ    = 3'd3,
    BR_BGTZ    = 3'd4,
    BR_BLTZ    = 3'd5,
    BR_BGEZ    = 3'd6,
    BR_ILLEGAL = 3'd7
  } br_op_e;

  localparam logic [1:0] SC_SNT = 2'b00;
  localparam logic [1:0] SC_WNT = 2'b01;
  localparam logic [1:0] SC_WT  = 2'b10;
  localparam logic [1:0] SC_ST  = 2'b11;

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// rtl/branch_predict_unit_sat_counter2.sv - 2-bit saturating up/down step function
// Pure combinational: next state from current state and resolved direction.
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       up_i,
  output logic [1:0] state_o
);

  always_comb begin
    state_o = state_i;
    if (up_i) begin
      if (state_i != SC_ST) state_o = state_i + 2'd1;
    end else begin
      if (state_i != SC_SNT) state_o = state_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX branch resolution plus direct-mapped 2-bit predictor table
// Optional performance counters are built when BRANCH_PERF_CNT_EN is defined.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [2:0]      ex_br_op,
  input  logic            ex_zero,
  input  logic            ex_neg,
  input  logic            ex_pred_taken,
  output logic            branch_taken,
  output logic            mispredict,
  output logic            br_err
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
`endif
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       cnt_q [DEPTH];
  logic [1:0]       cnt_d [DEPTH];
  logic             is_cond;
  logic             is_illegal;
  logic             taken_raw;
  logic             upd_en;
  logic [1:0]       upd_val;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  // No bypass: IF always sees the registered value, even on an index collision.
  assign if_pred_taken = cnt_q[if_idx][1];

  always_comb begin
    taken_raw  = 1'b0;
    is_cond    = 1'b1;
    is_illegal = 1'b0;
    case (br_op_e'(ex_br_op))
      BR_BEQ:     taken_raw = ex_zero;
      BR_BNE:     taken_raw = !ex_zero;
      BR_BLEZ:    taken_raw = ex_zero | ex_neg;
      BR_BGTZ:    taken_raw = !ex_zero & !ex_neg;
      BR_BLTZ:    taken_raw = ex_neg;
      BR_BGEZ:    taken_raw = !ex_neg;
      BR_ILLEGAL: begin
        is_cond    = 1'b0;
        is_illegal = 1'b1;
      end
      default:    is_cond = 1'b0;
    endcase
  end

  assign branch_taken = ex_valid & is_cond & taken_raw;
  assign mispredict   = ex_valid & is_cond & (taken_raw != ex_pred_taken);
  assign br_err       = ex_valid & is_illegal;
  assign upd_en       = ex_valid & !ex_stall & is_cond;

  sat_counter2 u_sat_counter2 (
    .state_i (cnt_q[ex_idx]),
    .up_i    (taken_raw),
    .state_o (upd_val)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en) cnt_d[ex_idx] = upd_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= SC_WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] br_count_q;
  logic [31:0] br_count_d;
  logic [31:0] mp_count_q;
  logic [31:0] mp_count_d;

  assign br_count_d = br_count_q + {31'd0, upd_en};
  assign mp_count_d = mp_count_q + {31'd0, upd_en & mispredict};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= 32'd0;
      mp_count_q <= 32'd0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
// Perf counter checks are compiled only with BRANCH_PERF_CNT_EN.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [2:0]  ex_br_op;
  logic        ex_zero;
  logic        ex_neg;
  logic        ex_pred_taken;
  logic        branch_taken;
  logic        mispredict;
  logic        br_err;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] br_count;
  logic [31:0] mp_count;
`endif

  typedef struct {
    logic taken;
    logic mp;
    logic err;
    logic pred;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] model [16];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         pm_br   = 0;
  int         pm_mp   = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_stall      (ex_stall),
    .ex_pc         (ex_pc),
    .ex_br_op      (ex_br_op),
    .ex_zero       (ex_zero),
    .ex_neg        (ex_neg),
    .ex_pred_taken (ex_pred_taken),
    .branch_taken  (branch_taken),
    .mispredict    (mispredict),
    .br_err        (br_err)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .br_count      (br_count),
    .mp_count      (mp_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_br(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

  function automatic logic exp_taken(input logic [2:0] op, input logic z, input logic n);
    case (op)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return z | n;
      3'd4:    return !z & !n;
      3'd5:    return n;
      3'd6:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] s, input logic up);
    if (up) return (s == 2'b11) ? s : s + 2'd1;
    return (s == 2'b00) ? s : s - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 2'b01;
    pm_br = 0;
    pm_mp = 0;
  endtask

  // Drive one EX/IF cycle, push the expectation, compare at the falling edge, update model at the rising edge.
  task automatic step(input logic [31:0] ipc, input logic v, input logic s, input logic [31:0] epc,
                      input logic [2:0] op, input logic z, input logic n, input logic p);
    exp_t e;
    exp_t got;
    logic t;
    if_pc = ipc; ex_valid = v; ex_stall = s; ex_pc = epc;
    ex_br_op = op; ex_zero = z; ex_neg = n; ex_pred_taken = p;
    t       = exp_taken(op, z, n);
    e.taken = v & is_br(op) & t;
    e.mp    = v & is_br(op) & (t != p);
    e.err   = v & (op == 3'd7);
    e.pred  = model[ipc[5:2]][1];
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("taken", {31'd0, branch_taken}, {31'd0, got.taken});
      check("mispredict", {31'd0, mispredict}, {31'd0, got.mp});
      check("br_err", {31'd0, br_err}, {31'd0, got.err});
      check("if_pred", {31'd0, if_pred_taken}, {31'd0, got.pred});
    end
    @(posedge clk);
    if (rst_n && v && !s && is_br(op)) begin
      model[epc[5:2]] = sat_step(model[epc[5:2]], t);
      pm_br++;
      if (t != p) pm_mp++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_stall = 1'b0; ex_br_op = 3'd0;
    ex_zero = 1'b0; ex_neg = 1'b0; ex_pred_taken = 1'b0;
  endtask

  // Reset lands while an EX update is pending; the update must be lost.
  task automatic mid_reset();
    if_pc = 32'h0; ex_pc = 32'h0; ex_valid = 1'b1; ex_stall = 1'b0;
    ex_br_op = 3'd1; ex_zero = 1'b1; ex_neg = 1'b0; ex_pred_taken = 1'b0;
    #2;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    check("pred_in_reset", {31'd0, if_pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] train_seq [5];
  logic       pz [3];
  logic       pn [3];

  initial begin
    train_seq[0] = 2'b10; train_seq[1] = 2'b11; train_seq[2] = 2'b11;
    train_seq[3] = 2'b11; train_seq[4] = 2'b11;
    pz[0] = 1'b0; pn[0] = 1'b0;
    pz[1] = 1'b0; pn[1] = 1'b1;
    pz[2] = 1'b1; pn[2] = 1'b0;

    rst_n = 1'b0;
    if_pc = 32'h0; ex_pc = 32'h0;
    idle_inputs();
    model_reset();
    #1;
    check("pred_por", {31'd0, if_pred_taken}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Dirty one entry, then reset mid-update and sweep the whole table.
    step(32'h0, 1'b1, 1'b0, 32'h4, 3'd1, 1'b1, 1'b0, 1'b0);
    mid_reset();
    for (int i = 0; i < 16; i++) begin
      step(i * 4, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("peek_reset", {30'd0, dut.cnt_q[i]}, 32'd1);
    end

    // Truth table with EX stalled so the table is untouched.
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 3; k++) begin
        step(32'h0, 1'b1, 1'b1, 32'h10, op[2:0], pz[k], pn[k], 1'b0);
      end
    end
    step(32'h0, 1'b1, 1'b1, 32'h10, 3'd3, 1'b0, 1'b1, 1'b1);
    check("blez_neg", {31'd0, branch_taken}, 32'd1);

    // Training to saturation at 0x40.
    for (int k = 0; k < 5; k++) begin
      step(32'h40, 1'b1, 1'b0, 32'h40, 3'd1, 1'b1, 1'b0, model[0][1]);
      check("train_cnt", {30'd0, dut.cnt_q[0]}, {30'd0, train_seq[k]});
    end
    step(32'h40, 1'b1, 1'b0, 32'h40, 3'd1, 1'b0, 1'b0, model[0][1]);
    check("untrain_cnt", {30'd0, dut.cnt_q[0]}, 32'd2);
    step(32'h40, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("pred_after_nt", {31'd0, model[0][1]}, 32'd1);

    // Same-index collision, starting from a fresh weak-NT entry.
    mid_reset();
    step(32'h80, 1'b1, 1'b0, 32'h80, 3'd1, 1'b1, 1'b0, 1'b0);
    step(32'h80, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("collide_cnt", {30'd0, dut.cnt_q[0]}, 32'd2);

    // Stall and invalid must not touch entry 1.
    step(32'h84, 1'b1, 1'b1, 32'h84, 3'd2, 1'b0, 1'b0, 1'b0);
    step(32'h84, 1'b0, 1'b0, 32'h84, 3'd1, 1'b1, 1'b0, 1'b0);
    step(32'h84, 1'b0, 1'b0, 32'h84, 3'd7, 1'b0, 1'b0, 1'b1);
    check("stall_cnt", {30'd0, dut.cnt_q[1]}, 32'd1);

`ifdef BRANCH_PERF_CNT_EN
    mid_reset();
    check("br_count_rst", br_count, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(32'h0, 1'b1, 1'b0, 32'h88, 3'd2, 1'b0, 1'b0, (k < 3) ? 1'b0 : 1'b1);
      if (k == 4 || k == 7) step(32'h0, 1'b1, 1'b1, 32'h88, 3'd2, 1'b0, 1'b0, 1'b0);
    end
    check("br_count", br_count, pm_br);
    check("mp_count", mp_count, pm_mp);
    check("br_count_10", br_count, 32'd10);
    check("mp_count_3", mp_count, 32'd3);
    dut.br_count_q = 32'hFFFF_FFFF;
    step(32'h0, 1'b1, 1'b0, 32'h88, 3'd2, 1'b0, 1'b0, 1'b1);
    check("br_count_wrap", br_count, 32'd0);
`endif

    if (sb.size() != 0) check("sb_leftover", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
